// File: rtl/chess_key_conditioner_pkg.sv
// rtl/chess_key_conditioner_pkg.sv - key indices, channel state encoding and default timing
package chess_key_conditioner_pkg;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_RIGHT = 3;

    // 10 ms debounce, 500 ms first repeat, 200 ms repeat period at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

    typedef enum logic [2:0] {
        KEY_RELEASED,
        KEY_PRESS_WAIT,
        KEY_HELD_DELAY,
        KEY_HELD_REPEAT,
        KEY_RELEASE_WAIT
    } key_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/chess_key_channel.sv
// rtl/chess_key_channel.sv - per-key synchroniser, debounce and auto-repeat FSM
module chess_key_channel
    import chess_key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw_n,
    output logic key_event,
    output logic held
);
    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync;
    logic             level;
    key_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             in_repeat, in_repeat_next;
    logic             held_next;

    assign level   = sync[1];
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Inverting ahead of the first flop makes the cleared synchroniser read as released
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync      <= '0;
            state     <= KEY_RELEASED;
            cnt       <= '0;
            in_repeat <= 1'b0;
            held      <= 1'b0;
        end else begin
            sync      <= {sync[0], ~key_raw_n};
            state     <= state_next;
            cnt       <= cnt_next;
            in_repeat <= in_repeat_next;
            held      <= held_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt_inc;
        in_repeat_next = in_repeat;
        held_next      = held;
        key_event      = 1'b0;
        case (state)
            KEY_RELEASED: begin
                cnt_next = '0;
                if (level) state_next = KEY_PRESS_WAIT;
            end
            KEY_PRESS_WAIT: begin
                if (!level) begin
                    state_next = KEY_RELEASED;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next     = KEY_HELD_DELAY;
                    cnt_next       = '0;
                    key_event      = 1'b1;
                    held_next      = 1'b1;
                    in_repeat_next = 1'b0;
                end
            end
            KEY_HELD_DELAY: begin
                if (!level) begin
                    state_next = KEY_RELEASE_WAIT;
                    cnt_next   = '0;
                end else if (cnt == DELAY_LAST) begin
                    state_next     = KEY_HELD_REPEAT;
                    cnt_next       = '0;
                    key_event      = REPEAT_EN;
                    in_repeat_next = 1'b1;
                end
            end
            KEY_HELD_REPEAT: begin
                if (!level) begin
                    state_next = KEY_RELEASE_WAIT;
                    cnt_next   = '0;
                end else if (cnt == PERIOD_LAST) begin
                    cnt_next  = '0;
                    key_event = REPEAT_EN;
                end
            end
            KEY_RELEASE_WAIT: begin
                // A release glitch resumes the held phase with a fresh repeat timer
                if (level) begin
                    state_next = in_repeat ? KEY_HELD_REPEAT : KEY_HELD_DELAY;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = KEY_RELEASED;
                    cnt_next   = '0;
                    held_next  = 1'b0;
                end
            end
            default: begin
                state_next = KEY_RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/chess_key_conditioner.sv
// rtl/chess_key_conditioner.sv - four debounced key channels with a pending-flag move pulse arbiter
module chess_key_conditioner
    import chess_key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic       clock,
    input  logic       resetApp,
    input  logic [3:0] KeyRaw,
    output logic       KeyLeft,
    output logic       KeyUp,
    output logic       KeyDown,
    output logic       KeyRight,
    output logic [3:0] KeyHeld
);
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("chess_key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [3:0] key_event;
    logic [3:0] pending;
    logic [3:0] grant;
    logic [3:0] pulse;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        chess_key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_EN)
        ) u_chan (
            .clock    (clock),
            .reset    (resetApp),
            .key_raw_n(KeyRaw[k]),
            .key_event(key_event[k]),
            .held     (KeyHeld[k])
        );
    end

    always_comb begin
        grant = '0;
        if (pending[KEY_LEFT])       grant[KEY_LEFT]  = 1'b1;
        else if (pending[KEY_RIGHT]) grant[KEY_RIGHT] = 1'b1;
        else if (pending[KEY_UP])    grant[KEY_UP]    = 1'b1;
        else if (pending[KEY_DOWN])  grant[KEY_DOWN]  = 1'b1;
    end

    // An event landing on an already-pending key is dropped, even if that key is served now
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            pending <= '0;
            pulse   <= '0;
        end else begin
            pending <= (pending & ~grant) | (key_event & ~pending);
            pulse   <= grant;
        end
    end

    assign KeyLeft  = pulse[KEY_LEFT];
    assign KeyUp    = pulse[KEY_UP];
    assign KeyDown  = pulse[KEY_DOWN];
    assign KeyRight = pulse[KEY_RIGHT];

endmodule

// File: doc/chess_key_conditioner.md
CHESS_KEY_CONDITIONER -- requirements
Module: chess_key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable sampled cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, held-key cycles from the first pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, cycles between later auto-repeat pulses.
REQ-004 Parameter REPEAT_EN, default 1, auto-repeat enable; 0 gives one pulse per press.
REQ-005 Port clock, input, 1, sole clock; all state on its rising edge.
REQ-006 Port resetApp, input, 1, asynchronous active-high reset.
REQ-007 Port KeyRaw, input, 4, raw active-low push-buttons, asynchronous to clock; bits [0]=Left, [1]=Up, [2]=Down, [3]=Right.
REQ-008 Ports KeyLeft, KeyUp, KeyDown, KeyRight, output, 1 each, registered single-cycle move pulses, active-high, consumed by the layout matrix stage.
REQ-009 Port KeyHeld, output, 4, registered debounced pressed level per key, same bit order as KeyRaw.

Function
REQ-010 Each KeyRaw bit SHALL pass a 2-flop synchroniser and be inverted to active-high before any other logic.
REQ-011 Each key SHALL run an independent FSM: RELEASED, PRESS_WAIT, HELD_DELAY, HELD_REPEAT, RELEASE_WAIT.
REQ-012 RELEASED->PRESS_WAIT when the synced level is 1; the debounce counter is cleared.
REQ-013 PRESS_WAIT returns to RELEASED if the level drops before the counter reaches DEBOUNCE_CYCLES-1; otherwise it goes to HELD_DELAY, raises an event and sets KeyHeld.
REQ-014 HELD_DELAY->HELD_REPEAT after REPEAT_DELAY cycles with the level still 1, raising an event if REPEAT_EN=1; HELD_REPEAT raises an event every REPEAT_PERIOD cycles.
REQ-015 From HELD_DELAY or HELD_REPEAT, a level of 0 goes to RELEASE_WAIT with the counter cleared; a glitch back to 1 before DEBOUNCE_CYCLES-1 returns to the prior held state with the repeat timer reset.
REQ-016 RELEASE_WAIT->RELEASED after DEBOUNCE_CYCLES stable cycles of 0; KeyHeld clears on that transition.
REQ-017 An event SHALL set a per-key pending flag; an event on a key whose flag is already set is dropped, not counted.
REQ-018 An output arbiter SHALL assert at most one move pulse per cycle, with priority Left > Right > Up > Down, and clear the served flag in the same cycle.
REQ-019 With no contention, a pulse SHALL be high exactly DEBOUNCE_CYCLES+3 cycles after the first edge sampling a stable press on KeyRaw.
REQ-020 A pulse SHALL be exactly one cycle wide; a deferred key pulses on the first cycle no higher-priority flag is pending.
REQ-021 Counters SHALL be sized for max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) and SHALL saturate, never wrap.
REQ-022 Parameter values below 1 are illegal; the block SHALL flag them at elaboration.

Reset
REQ-023 On resetApp high, all FSMs SHALL go to RELEASED, and counters, pending flags, synchronisers, the four move pulses and KeyHeld SHALL go to 0, immediately and without a clock edge.
REQ-024 A key held through reset deassertion SHALL be treated as a new press, with a full debounce before its pulse.
REQ-025 A reset during PRESS_WAIT or HELD_REPEAT SHALL discard in-flight events; no pulse occurs in the first 3 cycles after reset deassertion.

Structure
REQ-026 Key index constants (LEFT=0, UP=1, DOWN=2, RIGHT=3), the FSM state encoding and the default timing values SHALL live in the shared chess UI package.
REQ-027 The per-key synchroniser, debounce and repeat FSM SHALL be one sub-module, chess_key_channel, instantiated four times; the arbiter and output registers stay in the top level.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-028 Press Left cleanly at cycle 10 and hold 10 cycles -> KeyLeft high only in cycle 17; KeyHeld[0] rises in cycle 16.
REQ-029 Bounce Up as 1,0,1,0 cycles, then stable for 12 -> exactly one KeyUp pulse, 7 cycles after the stable start.
REQ-030 Hold Right 60 cycles with REPEAT_EN=1 -> KeyRight pulses at t0+7, t0+27, t0+35, t0+43, t0+51, t0+59; with REPEAT_EN=0 -> only t0+7.
REQ-031 Press Left and Down on the same edge -> KeyLeft in cycle t0+7 and KeyDown in t0+8; never both high in one cycle.
REQ-032 Assert resetApp mid-PRESS_WAIT with Up held, release reset at cycle R -> all outputs 0 during reset; KeyUp next high at R+7.
REQ-033 Release-bounce the held Down key 0,1,0 for 1 cycle each -> no extra KeyDown pulse; KeyHeld[2] clears only after 4 stable release cycles.
